// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg: shared types and sizing helpers for the pmem arbiter.
package pmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} arb_state_e;

    localparam int PERF_CNT_WIDTH = 32;

    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first pending port after last_grant.
module rr_picker
    import pmem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]             pending,
    input  logic [port_idx_w(NUM_PORTS)-1:0] last_grant,
    output logic                             valid,
    output logic [port_idx_w(NUM_PORTS)-1:0] grant
);

    localparam int IW = port_idx_w(NUM_PORTS);

    logic [IW-1:0] idx;

    // Walk from the farthest offset down so the nearest pending port wins.
    always_comb begin
        valid = |pending;
        grant = '0;
        idx = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = IW'((int'(last_grant) + i) % NUM_PORTS);
            if (pending[idx]) grant = idx;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin N-port arbiter onto one latched physical-memory line interface.
// Define PMEM_ARB_PERF_EN to add saturating grant and busy-cycle counters.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 256
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  req_read,
    input  logic [NUM_PORTS-1:0]                  req_write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]                  req_resp,
    output logic [LINE_WIDTH-1:0]                 req_rdata,
    output logic                                  pmem_read,
    output logic                                  pmem_write,
    output logic [ADDR_WIDTH-1:0]                 pmem_address,
    output logic [LINE_WIDTH-1:0]                 pmem_wdata,
    input  logic                                  pmem_resp,
    input  logic [LINE_WIDTH-1:0]                 pmem_rdata
`ifdef PMEM_ARB_PERF_EN
    ,
    input  logic                                       perf_clear,
    output logic [NUM_PORTS-1:0][PERF_CNT_WIDTH-1:0]   perf_grants,
    output logic [PERF_CNT_WIDTH-1:0]                  perf_busy_cycles
`endif
);

    localparam int IW = port_idx_w(NUM_PORTS);

    arb_state_e    state, state_next;
    logic [IW-1:0] last_grant, pick;
    logic          pick_valid, op_read, take;

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .pending    (req_read | req_write),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick)
    );

    assign take      = (state == IDLE) && pick_valid;
    assign req_rdata = pmem_rdata;

    always_comb begin
        state_next = (state == IDLE) ? (pick_valid ? BUSY : IDLE) :
                     (state == BUSY) ? (pmem_resp ? RECOVER : BUSY) : IDLE;
        pmem_read  = (state == BUSY) && op_read;
        pmem_write = (state == BUSY) && !op_read;
        req_resp   = ((state == BUSY) && pmem_resp) ? NUM_PORTS'(1) << last_grant : '0;
    end

    // last_grant doubles as the in-flight grant index while BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= IW'(NUM_PORTS - 1);
            op_read      <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                last_grant   <= pick;
                op_read      <= req_read[pick];
                pmem_address <= req_address[pick];
                pmem_wdata   <= req_wdata[pick];
            end
        end
    end

`ifdef PMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grants      <= '0;
            perf_busy_cycles <= '0;
        end else if (perf_clear) begin
            perf_grants      <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (take && (perf_grants[pick] != '1)) perf_grants[pick] <= perf_grants[pick] + 1'b1;
            if ((state == BUSY) && (perf_busy_cycles != '1)) perf_busy_cycles <= perf_busy_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed and randomized checks of pmem_arbiter against a round-robin model.
module tb_pmem_arbiter;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int LW = 256;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NP-1:0]          req_read, req_write, req_resp;
    logic [NP-1:0][AW-1:0]  req_address;
    logic [NP-1:0][LW-1:0]  req_wdata;
    logic [LW-1:0]          req_rdata, pmem_wdata, pmem_rdata;
    logic                   pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0]          pmem_address;
`ifdef PMEM_ARB_PERF_EN
    logic                   perf_clear = 1'b0;
    logic [NP-1:0][31:0]    perf_grants;
    logic [31:0]            perf_busy_cycles;
`endif

    int total = 0;
    int bad = 0;
    int last_g = NP - 1;

    pmem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write), .req_address(req_address), .req_wdata(req_wdata),
        .req_resp(req_resp), .req_rdata(req_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
`ifdef PMEM_ARB_PERF_EN
        , .perf_clear(perf_clear), .perf_grants(perf_grants), .perf_busy_cycles(perf_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [NP-1:0] pend);
        for (int i = 1; i <= NP; i++) if (pend[(last_g + i) % NP]) return (last_g + i) % NP;
        return -1;
    endfunction

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_read = '0;
        req_write = '0;
        req_address = '0;
        req_wdata = '0;
    endtask

    task automatic wait_busy(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if (pmem_read || pmem_write) begin
                n = i;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_reqs();
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        tick();
        tick();
        total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL reset_cmd got=%b exp=00", {pmem_read, pmem_write}); end
        total++; if (pmem_address !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", pmem_address); end
        total++; if (pmem_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", pmem_wdata); end
        total++; if (req_resp !== '0) begin bad++; $display("FAIL reset_resp got=%b exp=0", req_resp); end
        rst_n = 1'b1;
        last_g = NP - 1;
        tick();
    endtask

    task automatic test_single_read();
        int n;
        req_read[0] = 1'b1;
        req_address[0] = 16'h1240;
        wait_busy(n);
        total++; if (n !== 1) begin bad++; $display("FAIL sr_latency got=%0d exp=1", n); end
        total++; if ({pmem_read, pmem_write} !== 2'b10) begin bad++; $display("FAIL sr_cmd got=%b exp=10", {pmem_read, pmem_write}); end
        total++; if (pmem_address !== 16'h1240) begin bad++; $display("FAIL sr_addr got=%h exp=1240", pmem_address); end
        pmem_rdata = {32{8'hAB}};
        pmem_resp = 1'b1;
        #1;
        total++; if (req_resp !== 4'b0001) begin bad++; $display("FAIL sr_resp got=%b exp=0001", req_resp); end
        total++; if (req_rdata !== {32{8'hAB}}) begin bad++; $display("FAIL sr_rdata got=%h", req_rdata); end
        tick();
        req_read = '0;
        #1;
        total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL sr_recover_cmd got=%b exp=00", {pmem_read, pmem_write}); end
        total++; if (req_resp !== '0) begin bad++; $display("FAIL sr_recover_resp got=%b exp=0", req_resp); end
        pmem_resp = 1'b0;
        tick();
        total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL sr_idle_cmd got=%b exp=0", pmem_read); end
        last_g = 0;
    endtask

    task automatic test_collision();
        int n;
        req_read[0] = 1'b1;
        req_write[0] = 1'b1;
        req_address[0] = 16'h0300;
        wait_busy(n);
        total++; if ({pmem_read, pmem_write} !== 2'b10) begin bad++; $display("FAIL coll_cmd got=%b exp=10", {pmem_read, pmem_write}); end
        pmem_resp = 1'b1;
        #1;
        total++; if (req_resp !== 4'b0001) begin bad++; $display("FAIL coll_resp got=%b exp=0001", req_resp); end
        tick();
        pmem_resp = 1'b0;
        clear_reqs();
        tick();
        last_g = 0;
    endtask

    task automatic test_stability();
        int n;
        req_write[1] = 1'b1;
        req_address[1] = 16'h00A0;
        req_wdata[1] = {64{4'h5}};
        wait_busy(n);
        total++; if ({pmem_read, pmem_write} !== 2'b01) begin bad++; $display("FAIL stab_cmd got=%b exp=01", {pmem_read, pmem_write}); end
        req_address[1] = 16'hFFE0;
        req_wdata[1] = '1;
        req_write[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({pmem_write, pmem_address} !== {1'b1, 16'h00A0}) begin bad++; $display("FAIL stab_addr got=%b/%h exp=1/00a0", pmem_write, pmem_address); end
            total++; if (pmem_wdata !== {64{4'h5}}) begin bad++; $display("FAIL stab_wdata got=%h", pmem_wdata); end
        end
        pmem_resp = 1'b1;
        #1;
        total++; if (req_resp !== 4'b0010) begin bad++; $display("FAIL stab_resp got=%b exp=0010", req_resp); end
        tick();
        pmem_resp = 1'b0;
        clear_reqs();
        tick();
        last_g = 1;
    endtask

    task automatic test_wrap();
        int n;
        req_read[3] = 1'b1;
        wait_busy(n);
        pmem_resp = 1'b1;
        #1;
        total++; if (req_resp !== 4'b1000) begin bad++; $display("FAIL wrap_first got=%b exp=1000", req_resp); end
        tick();
        pmem_resp = 1'b0;
        clear_reqs();
        tick();
        last_g = 3;
        req_read[1] = 1'b1;
        req_write[3] = 1'b1;
        wait_busy(n);
        pmem_resp = 1'b1;
        #1;
        total++; if ({req_resp, pmem_read} !== 5'b00101) begin bad++; $display("FAIL wrap_p1 got=%b/%b exp=0010/1", req_resp, pmem_read); end
        tick();
        pmem_resp = 1'b0;
        wait_busy(n);
        total++; if (n !== 2) begin bad++; $display("FAIL wrap_gap got=%0d exp=2", n); end
        pmem_resp = 1'b1;
        #1;
        total++; if ({req_resp, pmem_write} !== 5'b10001) begin bad++; $display("FAIL wrap_p3 got=%b/%b exp=1000/1", req_resp, pmem_write); end
        tick();
        pmem_resp = 1'b0;
        clear_reqs();
        tick();
        last_g = 3;
    endtask

    task automatic test_back_to_back();
        int n, exp_p;
        req_read = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            wait_busy(n);
            total++; if (n !== ((k == 0) ? 1 : 2)) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", k, n, (k == 0) ? 1 : 2); end
            exp_p = model_pick(4'b0011);
            pmem_resp = 1'b1;
            #1;
            total++; if (req_resp !== onehot(exp_p)) begin bad++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", k, req_resp, onehot(exp_p)); end
            last_g = exp_p;
            tick();
            pmem_resp = 1'b0;
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_random(input int iters);
        int n, exp_p, lat, r;
        logic [NP-1:0] pend;
        logic exp_rd;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_wdata, rd;
        for (int it = 0; it < iters; it++) begin
            pend = '0;
            while (pend == '0) begin
                for (int p = 0; p < NP; p++) begin
                    r = $urandom_range(0, 3);
                    req_read[p] = r[0];
                    req_write[p] = r[1];
                    req_address[p] = AW'($urandom());
                    req_wdata[p] = rand_line();
                end
                pend = req_read | req_write;
            end
            exp_p = model_pick(pend);
            exp_rd = req_read[exp_p];
            exp_addr = req_address[exp_p];
            exp_wdata = req_wdata[exp_p];
            wait_busy(n);
            total++; if (n !== 1) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d exp=1", it, n); end
            lat = $urandom_range(0, 3);
            for (int j = 0; j <= lat; j++) begin
                total++; if ({pmem_read, pmem_write, pmem_address} !== {exp_rd, !exp_rd, exp_addr}) begin bad++; $display("FAIL rnd_cmd[%0d] got=%b%b/%h exp=%b%b/%h", it, pmem_read, pmem_write, pmem_address, exp_rd, !exp_rd, exp_addr); end
                total++; if (pmem_wdata !== exp_wdata) begin bad++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", it, pmem_wdata, exp_wdata); end
                req_read = NP'($urandom());
                req_write = NP'($urandom());
                for (int p = 0; p < NP; p++) req_address[p] = AW'($urandom());
                if (j < lat) tick();
            end
            rd = rand_line();
            pmem_rdata = rd;
            pmem_resp = 1'b1;
            #1;
            total++; if (req_resp !== onehot(exp_p)) begin bad++; $display("FAIL rnd_resp[%0d] got=%b exp=%b", it, req_resp, onehot(exp_p)); end
            total++; if (req_rdata !== rd) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", it, req_rdata, rd); end
            tick();
            pmem_resp = 1'b0;
            clear_reqs();
            #1;
            total++; if ({pmem_read, pmem_write, req_resp} !== '0) begin bad++; $display("FAIL rnd_recover[%0d] got=%b%b/%b exp=0", it, pmem_read, pmem_write, req_resp); end
            last_g = exp_p;
            tick();
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        req_read[2] = 1'b1;
        wait_busy(n);
        pmem_resp = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL rst_mid_cmd got=%b exp=00", {pmem_read, pmem_write}); end
        total++; if (req_resp !== '0) begin bad++; $display("FAIL rst_mid_resp got=%b exp=0", req_resp); end
        total++; if (pmem_address !== '0) begin bad++; $display("FAIL rst_mid_addr got=%h exp=0", pmem_address); end
        clear_reqs();
        pmem_resp = 1'b0;
        tick();
        rst_n = 1'b1;
        last_g = NP - 1;
`ifdef PMEM_ARB_PERF_EN
        total++; if ({perf_grants, perf_busy_cycles} !== '0) begin bad++; $display("FAIL perf_zero got=%h/%h exp=0", perf_grants, perf_busy_cycles); end
`endif
        req_read = 4'b0101;
        wait_busy(n);
        total++; if (n !== 1) begin bad++; $display("FAIL rst_regrant_latency got=%0d exp=1", n); end
        pmem_resp = 1'b1;
        #1;
        total++; if (req_resp !== 4'b0001) begin bad++; $display("FAIL rst_regrant got=%b exp=0001", req_resp); end
        tick();
        pmem_resp = 1'b0;
        clear_reqs();
        tick();
        last_g = 0;
`ifdef PMEM_ARB_PERF_EN
        total++; if ({perf_grants[0], perf_busy_cycles} !== {32'd1, 32'd1}) begin bad++; $display("FAIL perf_count got=%0d/%0d exp=1/1", perf_grants[0], perf_busy_cycles); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_collision();
        test_stability();
        test_wrap();
        test_back_to_back();
        test_random(40);
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
